// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Inter-stage register for the 5-stage pipeline. It carries a control bundle
//   and a datapath bundle behind a valid/ready handshake. A 2-entry skid buffer
//   means in_ready depends only on registered state, never on out_ready.
//   flush inserts a bubble. A saturating counter tracks downstream stalls.
//
// Ports
//   clk, reset         rising-edge clock, async active-low reset
//   flush              sync; drops held entries and any same-cycle input
//   in_valid/in_ready  upstream handshake (in_ready is registered)
//   in_ctrl/in_data    upstream bundles
//   out_valid/out_ready downstream handshake
//   out_ctrl           M.ctrl when valid, else CTRL_SAFE
//   out_data           M.data (holds last value while invalid)
//   stall_cnt/clr_cnt  saturating stall-cycle count and its sync clear
module pipe_stage_skid #(
    parameter int                CTRL_W    = 4,
    parameter int                DATA_W    = 32,
    parameter logic [CTRL_W-1:0] CTRL_SAFE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    entry_t mReg, sReg, inEntry;
    logic   inReady, outValid;
    logic   inXfer, outXfer;

    assign inEntry = '{ctrl: in_ctrl, data: in_data};
    assign inXfer  = in_valid & inReady;
    assign outXfer = outValid & out_ready;

    // inReady/outValid are registered copies of the occupancy decode, so
    // both handshake outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            mReg     <= '0;
            sReg     <= '0;
        end else if (flush) begin
            // Bubble insertion: M/S keep their contents but are no longer valid.
            state    <= EMPTY;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (inXfer) begin
                        mReg     <= inEntry;
                        state    <= ONE;
                        outValid <= 1'b1;
                    end
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        mReg <= inEntry;
                    end else if (inXfer) begin
                        sReg    <= inEntry;
                        state   <= FULL;
                        inReady <= 1'b0;
                    end else if (outXfer) begin
                        state    <= EMPTY;
                        outValid <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (outXfer) begin
                        mReg    <= sReg;
                        state   <= ONE;
                        inReady <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over increment. Flush neither clears nor counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (outValid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid;
    assign out_ctrl  = outValid ? mReg.ctrl : CTRL_SAFE;
    assign out_data  = mReg.data;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed inter-stage control registers of the 5-stage RISC-V pipeline.
- One instance sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a control bundle plus a datapath bundle.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush (bubble insertion) and a saturating stall counter.
- Control fields are forced to their safe value whenever the stage holds a bubble.

Parameters:
- CTRL_W, 4, width of the control bundle (e.g. RegWrite, MemWrite, ResultSrc[1:0]).
- DATA_W, 32, width of the datapath bundle (PC, operands, immediates, concatenated by the instantiator).
- CTRL_SAFE, 0, CTRL_W-bit value driven on out_ctrl when no valid entry is presented. It must deassert all write enables.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- flush  in  1  synchronous; discards all held entries and any same-cycle input.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  this stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream datapath bundle.
- out_valid  out  1  an entry is presented downstream.
- out_ready  in  1  downstream accepts the presented entry.
- out_ctrl  out  CTRL_W  control bundle; equals CTRL_SAFE when out_valid=0.
- out_data  out  DATA_W  datapath bundle; holds its last value when out_valid=0 (don't-care).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Handshake and storage:
  - Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
  - Storage is a main register (M) feeding the outputs plus a skid register (S).
- States, encoded by occupancy:
  - EMPTY (0 entries): in_ready=1, out_valid=0.
  - ONE (M full): in_ready=1, out_valid=1.
  - FULL (M and S full): in_ready=0, out_valid=1.
- in_ready is a registered output: in_ready = !(state==FULL). There is no combinational path from out_ready to in_ready.
- Transitions when flush=0:
  - EMPTY + in xfer -> ONE, with M loaded.
  - ONE + in xfer + out xfer -> ONE, with M reloaded from the input.
  - ONE + in xfer only -> FULL, with S loaded.
  - ONE + out xfer only -> EMPTY.
  - FULL + out xfer -> ONE, with M<=S.
  - Any other combination holds state.
- Latency and ordering:
  - Latency is 1 cycle in to out when EMPTY.
  - Order is strictly FIFO; there is no loss or duplication under any out_ready pattern.
  - Throughput is 1 entry/cycle while out_ready=1.
- Flush:
  - flush=1 at a clock edge sets next state to EMPTY regardless of in_valid or out_ready. A same-cycle input is dropped.
  - Next cycle: out_valid=0 and out_ctrl=CTRL_SAFE.
  - A same-cycle out xfer still counts as completed for the downstream consumer.
- out_ctrl = out_valid ? M.ctrl : CTRL_SAFE, decoded combinationally from registered state.
- Stall counter:
  - Increments by 1 each cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1; it does not wrap.
  - clr_cnt has priority over increment (the counter reads 0 the next cycle).
  - Flush does not clear stall_cnt.
- Reset (reset=0, asynchronous):
  - Outputs immediately: state=EMPTY, out_valid=0, in_ready=1, out_ctrl=CTRL_SAFE, out_data=0, stall_cnt=0.
  - M and S contents are cleared to 0.
  - Reset asserted mid-transfer discards all entries. The first edge after release behaves as EMPTY.
- M and S data registers are written only on the load conditions above, never otherwise.

Test Plan:
- Reset mid-stream: fill to FULL with ctrl=4'hF, data=A/B, then pull reset low between edges -> out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0 without waiting for a clock edge.
- Streaming: out_ready=1, in_valid=1 with data 1..8 on consecutive cycles -> out_data 1..8 one cycle later, no gaps, stall_cnt stays 0.
- Backpressure: stream 1,2,3 and drop out_ready at cycle 2 for 3 cycles -> in_ready falls after FULL, outputs appear as 1,2,3 in order, stall_cnt=3.
- Flush with hazard: FULL holding ctrl=4'b1011, assert flush while in_valid=1 with data 9 -> next cycle out_valid=0 and out_ctrl=CTRL_SAFE, and data 9 never appears at the output.
- Safe control on bubble: in_valid=0 while in_ctrl=4'hF -> out_ctrl=CTRL_SAFE every cycle.
- Counter saturation: CNT_W=3 with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds. clr_cnt together with a stall cycle -> 0 the next cycle.
